// File: rtl/histogram_accumulator.sv
// histogram_accumulator
//   Builds a 256-bin intensity histogram from one streamed 8-bit pixel frame per start pulse.
//   The finished histogram is held stable (o_hist_valid) until the next start.
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        clear bins/count/overflow and begin accumulating
//   i_pixel_valid  i_pixel / i_pixel_last valid this cycle
//   i_pixel        pixel intensity, used directly as the bin index
//   i_pixel_last   final pixel of the frame (qualified by valid)
//   o_ready        pixels are accepted (accumulating)
//   o_busy         accumulating
//   o_hist_valid   histogram complete and frozen
//   o_histogram    256 registered bin counts, saturating at 2**BIN_W-1
//   o_pixel_count  pixels accepted in the current/last frame, saturating
//   o_overflow     sticky: some bin saturated during this frame
module histogram_accumulator #(
  parameter int unsigned BIN_W   = 16,
  parameter int unsigned COUNT_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_pixel_valid,
  input  logic [7:0]         i_pixel,
  input  logic               i_pixel_last,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_hist_valid,
  output logic [BIN_W-1:0]   o_histogram [256],
  output logic [COUNT_W-1:0] o_pixel_count,
  output logic               o_overflow
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [BIN_W-1:0]   BinMax   = '1;
  localparam logic [COUNT_W-1:0] CountMax = '1;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bins_q [256];
  logic [BIN_W-1:0]   bins_d [256];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               accept;

  // Start has priority: a pixel arriving with start is dropped entirely.
  assign accept = (state_q == StAccum) && i_pixel_valid && !i_start;

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_start) begin
      state_d = StAccum;
      count_d = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < 256; i++) begin
        bins_d[i] = '0;
      end
    end else if (accept) begin
      // A full bin holds its value and flags the frame as overflowed.
      if (bins_q[i_pixel] == BinMax) begin
        ovf_d = 1'b1;
      end else begin
        bins_d[i_pixel] = bins_q[i_pixel] + BIN_W'(1);
      end
      if (count_q != CountMax) begin
        count_d = count_q + COUNT_W'(1);
      end
      if (i_pixel_last) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      bins_q  <= '{default: '0};
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bins_q  <= bins_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready       = (state_q == StAccum);
  assign o_busy        = (state_q == StAccum);
  assign o_hist_valid  = (state_q == StDone);
  assign o_histogram   = bins_q;
  assign o_pixel_count = count_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator: a full-size instance checked against a
// behavioural histogram model, plus a BIN_W=4 / COUNT_W=5 instance for saturation boundaries.
module tb_histogram_accumulator;

  localparam int unsigned BinW    = 16;
  localparam int unsigned CountW  = 24;
  localparam int unsigned SBinW   = 4;
  localparam int unsigned SCountW = 5;
  localparam int          BinMax   = (1 << BinW) - 1;
  localparam int          CountMax = (1 << CountW) - 1;
  localparam int          SBinMax   = (1 << SBinW) - 1;
  localparam int          SCountMax = (1 << SCountW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              valid = 1'b0;
  logic              last = 1'b0;
  logic [7:0]        pixel = '0;
  logic              ready, busy, hvalid, ovf;
  logic [BinW-1:0]   hist [256];
  logic [CountW-1:0] cnt;

  logic               s_start = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic [7:0]         s_pixel = '0;
  logic               s_ready, s_busy, s_hvalid, s_ovf;
  logic [SBinW-1:0]   s_hist [256];
  logic [SCountW-1:0] s_cnt;

  histogram_accumulator #(.BIN_W(BinW), .COUNT_W(CountW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pixel_valid(valid),
    .i_pixel(pixel), .i_pixel_last(last), .o_ready(ready), .o_busy(busy),
    .o_hist_valid(hvalid), .o_histogram(hist), .o_pixel_count(cnt), .o_overflow(ovf)
  );

  histogram_accumulator #(.BIN_W(SBinW), .COUNT_W(SCountW)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_pixel_valid(s_valid),
    .i_pixel(s_pixel), .i_pixel_last(s_last), .o_ready(s_ready), .o_busy(s_busy),
    .o_hist_valid(s_hvalid), .o_histogram(s_hist), .o_pixel_count(s_cnt), .o_overflow(s_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-bin counts for the full-size instance.
  int model_bins [256];
  int model_count;
  bit model_ovf;
  int first_bad;

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) model_bins[i] = 0;
    model_count = 0;
    model_ovf   = 1'b0;
  endfunction

  function automatic void model_accept(input int p);
    if (model_bins[p] < BinMax) model_bins[p]++;
    else model_ovf = 1'b1;
    if (model_count < CountMax) model_count++;
  endfunction

  // Number of DUT bins that disagree with the model; first_bad records the first one.
  function automatic int bin_mismatches();
    int n = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (hist[i] !== BinW'(model_bins[i])) begin
        if (first_bad < 0) first_bad = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input int p, input bit l);
    valid = 1'b1;
    pixel = 8'(p);
    last  = l;
    tick();
    model_accept(p);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic test_reset();
    int nb;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0) begin
      n_fail++;
      $display("FAIL reset_bins: %0d bins nonzero (first %0d = %0d), required 0", nb, first_bad,
               hist[first_bad]);
    end
    n_checks++;
    if ({ready, busy, hvalid, ovf} !== 4'b0000 || cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/busy/hv/ovf=%b count=%0d, required 0000 and 0",
               {ready, busy, hvalid, ovf}, cnt);
    end
    rst_n = 1'b1;
    tick();
    // Pixels in IDLE must have no effect.
    for (int i = 0; i < 10; i++) send(i * 25, i == 9);
    model_clear();
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0 || cnt !== '0 || busy !== 1'b0 || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignored: bad bins=%0d count=%0d busy=%b hv=%b, required 0,0,0,0",
               nb, cnt, busy, hvalid);
    end
  endtask

  task automatic test_basic();
    int nb;
    do_start();
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b1 || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accum_state: busy=%b rdy=%b hv=%b, required 1,1,0", busy, ready, hvalid);
    end
    send(5, 0);
    send(5, 0);
    send(5, 0);
    n_checks++;
    if (hist[5] !== BinW'(3) || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_back_to_back: bin5=%0d hv=%b, required 3,0", hist[5], hvalid);
    end
    send(200, 1);
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0 || hist[5] !== BinW'(3) || hist[200] !== BinW'(1)) begin
      n_fail++;
      $display("FAIL basic_bins: bad=%0d bin5=%0d bin200=%0d, required 0,3,1", nb, hist[5],
               hist[200]);
    end
    n_checks++;
    if (cnt !== CountW'(4) || hvalid !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: count=%0d hv=%b busy=%b ovf=%b, required 4,1,0,0", cnt, hvalid,
               busy, ovf);
    end
  endtask

  task automatic test_start_wins();
    do_start();
    send(1, 0);
    start = 1'b1;
    valid = 1'b1;
    pixel = 8'd7;
    last  = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    model_clear();
    n_checks++;
    if (hist[7] !== '0 || hist[1] !== '0 || cnt !== '0 || busy !== 1'b1 || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_wins: bin7=%0d bin1=%0d count=%0d busy=%b hv=%b, required 0,0,0,1,0",
               hist[7], hist[1], cnt, busy, hvalid);
    end
    send(7, 1);
    n_checks++;
    if (hist[7] !== BinW'(1) || cnt !== CountW'(1) || hvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_wins_resume: bin7=%0d count=%0d hv=%b, required 1,1,1", hist[7], cnt,
               hvalid);
    end
  endtask

  task automatic test_done_frozen();
    int nb;
    // Bench model is not updated here: nothing may change while DONE.
    for (int i = 0; i < 256; i++) begin
      valid = 1'b1;
      pixel = 8'(i);
      last  = 1'($urandom_range(0, 1));
      tick();
    end
    valid = 1'b0;
    last  = 1'b0;
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0 || cnt !== CountW'(model_count)) begin
      n_fail++;
      $display("FAIL done_frozen: bad bins=%0d count=%0d, required 0 and %0d", nb, cnt,
               model_count);
    end
    n_checks++;
    if (ready !== 1'b0 || hvalid !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags: rdy=%b hv=%b ovf=%b, required 0,1,0", ready, hvalid, ovf);
    end
    do_start();
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0 || cnt !== '0 || busy !== 1'b1 || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: bad bins=%0d count=%0d busy=%b hv=%b, required 0,0,1,0",
               nb, cnt, busy, hvalid);
    end
    send(3, 1);
  endtask

  task automatic test_saturation();
    for (int frame = 0; frame < 2; frame++) begin
      int n;
      n = (frame == 0) ? 17 : 40;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      n_checks++;
      if (s_ovf !== 1'b0 || s_cnt !== '0 || s_hist[9] !== '0) begin
        n_fail++;
        $display("FAIL sat_start_clear: ovf=%b count=%0d bin9=%0d, required 0,0,0", s_ovf, s_cnt,
                 s_hist[9]);
      end
      for (int i = 0; i < n; i++) begin
        s_valid = 1'b1;
        s_pixel = 8'd9;
        s_last  = (i == n - 1);
        tick();
        if (frame == 0 && i == SBinMax - 1) begin
          n_checks++;
          if (s_hist[9] !== SBinW'(SBinMax) || s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_edge_full: bin9=%0d ovf=%b, required %0d,0", s_hist[9], s_ovf,
                     SBinMax);
          end
        end
        if (frame == 0 && i == SBinMax) begin
          n_checks++;
          if (s_hist[9] !== SBinW'(SBinMax) || s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_edge_over: bin9=%0d ovf=%b, required %0d,1", s_hist[9], s_ovf,
                     SBinMax);
          end
        end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      n_checks++;
      if (s_hist[9] !== SBinW'((n < SBinMax) ? n : SBinMax) || s_ovf !== 1'b1 ||
          s_cnt !== SCountW'((n < SCountMax) ? n : SCountMax) || s_hvalid !== 1'b1 ||
          s_hist[8] !== '0) begin
        n_fail++;
        $display("FAIL sat_frame%0d: bin9=%0d ovf=%b count=%0d hv=%b bin8=%0d, required %0d,1,%0d,1,0",
                 frame, s_hist[9], s_ovf, s_cnt, s_hvalid, s_hist[8],
                 (n < SBinMax) ? n : SBinMax, (n < SCountMax) ? n : SCountMax);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int nb;
    int p;
    do_start();
    for (int i = 0; i < 100; i++) send(int'($urandom_range(0, 255)), 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0 || cnt !== '0 || busy !== 1'b0 || ready !== 1'b0 || hvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: bad bins=%0d count=%0d busy=%b rdy=%b hv=%b, required all 0",
               nb, cnt, busy, ready, hvalid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    p = int'($urandom_range(0, 255));
    send(p, 1);
    nb = bin_mismatches();
    n_checks++;
    if (cnt !== CountW'(1) || nb !== 0 || hvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart: count=%0d bad bins=%0d hv=%b, required 1,0,1", cnt, nb,
               hvalid);
    end
  endtask

  task automatic test_random_frame();
    int     nb;
    longint sum;
    do_start();
    for (int k = 0; k < 4096; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          valid = 1'b0;
          pixel = 8'($urandom);
          last  = 1'($urandom_range(0, 1));
          tick();
        end
      end
      // Half the pixels land in a narrow hot band so some bins grow large.
      if ($urandom_range(0, 1) == 0) send(int'($urandom_range(100, 107)), k == 4095);
      else send(int'($urandom_range(0, 255)), k == 4095);
    end
    nb = bin_mismatches();
    n_checks++;
    if (nb !== 0) begin
      n_fail++;
      $display("FAIL random_bins: %0d bins differ, first bin %0d = %0d, required %0d", nb,
               first_bad, hist[first_bad], model_bins[first_bad]);
    end
    sum = 0;
    for (int i = 0; i < 256; i++) sum += longint'(hist[i]);
    n_checks++;
    if (sum !== 64'd4096 || cnt !== CountW'(4096)) begin
      n_fail++;
      $display("FAIL random_sum: sum=%0d count=%0d, required 4096,4096", sum, cnt);
    end
    n_checks++;
    if (hvalid !== 1'b1 || ovf !== model_ovf) begin
      n_fail++;
      $display("FAIL random_done: hv=%b ovf=%b, required 1,%b", hvalid, ovf, model_ovf);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_start_wins();
    test_done_frozen();
    test_saturation();
    test_reset_midframe();
    test_random_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
